writeback_tracker: RTL and testbench
====================================

WRITEBACK_TRACKER -- requirements
Module: writeback_tracker

Interface
REQ-001 Parameter DIV_LATENCY, default 32, sets the number of stall cycles per divide; legal range 1..63.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reg_write_id_i  input  1  instruction in ID writes a register.
REQ-005 rd_address_id_i  input  5  destination of instruction in ID.
REQ-006 mem_to_reg_id_i  input  1  instruction in ID is a load.
REQ-007 div_id_i  input  1  instruction in ID is a multi-cycle DIV/DIVU/REM/REMU.
REQ-008 branch_id_i  input  1  instruction in ID is a branch compared in ID.
REQ-009 rs1_address_id_i, rs2_address_id_i  input  5 each  source registers of instruction in ID.
REQ-010 flush_id_i  input  1  annul instruction in ID (taken branch/jump).
REQ-011 reg_write_ex_o, rd_address_ex_o  output  1/5  EX-stage destination info.
REQ-012 reg_write_mem_o, rd_address_mem_o  output  1/5  MEM-stage destination info, feeds forwarding unit.
REQ-013 reg_write_wb_o, rd_address_wb_o  output  1/5  WB-stage destination info, feeds forwarding unit.
REQ-014 stall_o  output  1  hold PC and IF/ID register.
REQ-015 ex_hold_o  output  1  hold ID/EX register contents (divide in progress).
REQ-016 div_busy_o  output  1  divide FSM in BUSY.

Function
REQ-017 Tracker SHALL register {reg_write, rd, is_load, is_div} ID->EX->MEM->WB, one stage per cycle when not stalled.
REQ-018 rd == 0 SHALL force reg_write = 0 at ID->EX capture.
REQ-019 Load-use: EX holds load with reg_write=1 and rd matching rs1 or rs2 in ID -> stall_o=1 that cycle, EX receives bubble next cycle, MEM/WB advance.
REQ-020 Branch-in-ID: branch_id_i=1 and (EX reg_write with rd match, or MEM load with rd match) -> stall_o=1, EX bubble; MEM/WB forwarding covers all other cases.
REQ-021 Divide FSM states IDLE, BUSY; IDLE with is_div in EX -> stall_o=1, ex_hold_o=1, counter loads DIV_LATENCY-1, go BUSY.
REQ-022 BUSY with counter != 0 -> stall_o=1, ex_hold_o=1, counter decrements, MEM receives bubble each cycle.
REQ-023 BUSY with counter == 0 -> stall_o=0, ex_hold_o=0, EX advances to MEM, go IDLE; total stall cycles = DIV_LATENCY.
REQ-024 Divide hold SHALL take priority over load-use/branch stall; EX is held, never bubbled, while ex_hold_o=1.
REQ-025 flush_id_i=1 with stall_o=0 SHALL capture a bubble into EX; with stall_o=1 flush_id_i SHALL be ignored.
REQ-026 Bubble SHALL be reg_write=0, rd=0, is_load=0, is_div=0.
REQ-027 stall_o and ex_hold_o SHALL be combinational from registered state and ID inputs, no added latency.

Reset
REQ-028 reset=1 SHALL immediately clear all stage registers to bubble, FSM to IDLE, counter to 0.
REQ-029 All outputs SHALL read 0 during reset, including mid-divide.
REQ-030 First instruction after reset release SHALL be captured on the first rising edge.

Structure
REQ-031 Shared package SHALL hold stage record typedef {reg_write, rd[4:0], is_load, is_div}, FSM state enum, and DIV_LATENCY default.
REQ-032 Divide FSM plus counter SHALL be sub-module div_stall_fsm; stage registers and hazard compare stay in top.

Verification
REQ-033 Load x5 then ADD x6,x5,x1 -> one stall_o cycle, one EX bubble, then reg_write_mem_o=1/rd=5 followed by rd=6.
REQ-034 DIV x7 with DIV_LATENCY=4 -> stall_o high exactly 4 cycles, MEM bubbles 3 cycles, then rd_address_mem_o=7.
REQ-035 Writes to x0 -> reg_write_ex/mem/wb_o stay 0 in all stages.
REQ-036 ADD x3 in EX, BEQ x3,x4 in ID -> 1 stall; load x3 in EX -> 2 stalls.
REQ-037 reset asserted at BUSY counter=2 -> all outputs 0 same cycle, FSM IDLE, no residual stall after release.
REQ-038 flush_id_i with reg_write_id_i=1, rd=9 -> reg_write_ex_o=0 next cycle; same during stall -> flush ignored.

Source files
------------

// File: rtl/writeback_tracker_pkg.sv
// rtl/writeback_tracker_pkg.sv - shared types and constants for the writeback tracker
//
// Purpose: pipeline stage record, divide FSM state encoding, default divide
//          latency and a small source/destination match helper.
// Ports:   none (package).

package writeback_tracker_pkg;

  // Stall cycles per divide; legal range 1..63 (counter is 6 bits wide).
  localparam int DIV_LATENCY_DEFAULT = 32;
  localparam int DIV_CNT_W           = 6;

  // Destination information carried from ID down to WB.
  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
    logic       is_load;
    logic       is_div;
  } stage_t;

  // All-zero record inserted wherever a stage is bubbled.
  localparam stage_t STAGE_BUBBLE = '0;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  // True when a producer's destination is read by either source of the ID instruction.
  function automatic logic src_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return (rd == rs1) || (rd == rs2);
  endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// rtl/div_stall_fsm.sv - multi-cycle divide stall sequencer
//
// Purpose: holds the EX stage while a divide occupies it for DIV_LATENCY
//          cycles in total.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   div_in_ex  in   EX stage holds a divide
//   ex_hold    out  hold EX contents this cycle (combinational from state)
//   div_busy   out  FSM is in BUSY

module div_stall_fsm
  import writeback_tracker_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic div_in_ex,
  output logic ex_hold,
  output logic div_busy
);

  localparam logic [DIV_CNT_W-1:0] LOAD_VALUE = DIV_CNT_W'(DIV_LATENCY - 1);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] count;

  // The IDLE cycle that spots the divide is itself a stall cycle, so the
  // counter starts at DIV_LATENCY-1 and BUSY releases when it reaches zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_in_ex) begin
            state <= DIV_BUSY;
            count <= LOAD_VALUE;
          end
        end
        DIV_BUSY: begin
          if (count != '0) begin
            count <= count - DIV_CNT_W'(1);
          end else begin
            state <= DIV_IDLE;
          end
        end
        default: begin
          state <= DIV_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ex_hold = 1'b0;
    case (state)
      DIV_IDLE: ex_hold = div_in_ex;
      DIV_BUSY: ex_hold = (count != '0);
      default:  ex_hold = 1'b0;
    endcase
  end

  assign div_busy = (state == DIV_BUSY);

endmodule

// File: rtl/writeback_tracker.sv
// rtl/writeback_tracker.sv - destination tracking and hazard stall generation ID->WB
//
// Purpose: carries {reg_write, rd, is_load, is_div} through EX/MEM/WB, detects
//          load-use and branch-in-ID hazards, and sequences divide stalls.
// Ports:
//   clk, reset                          clock / asynchronous active-high reset
//   reg_write_id_i, rd_address_id_i     ID destination info
//   mem_to_reg_id_i, div_id_i           ID instruction is a load / divide
//   branch_id_i                         ID instruction is a branch compared in ID
//   rs1_address_id_i, rs2_address_id_i  ID source registers
//   flush_id_i                          annul the ID instruction
//   reg_write_{ex,mem,wb}_o, rd_address_{ex,mem,wb}_o  stage destination info
//   stall_o                             hold PC and IF/ID
//   ex_hold_o                           hold ID/EX (divide in progress)
//   div_busy_o                          divide FSM in BUSY

module writeback_tracker
  import writeback_tracker_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_write_id_i,
  input  logic [4:0] rd_address_id_i,
  input  logic       mem_to_reg_id_i,
  input  logic       div_id_i,
  input  logic       branch_id_i,
  input  logic [4:0] rs1_address_id_i,
  input  logic [4:0] rs2_address_id_i,
  input  logic       flush_id_i,
  output logic       reg_write_ex_o,
  output logic [4:0] rd_address_ex_o,
  output logic       reg_write_mem_o,
  output logic [4:0] rd_address_mem_o,
  output logic       reg_write_wb_o,
  output logic [4:0] rd_address_wb_o,
  output logic       stall_o,
  output logic       ex_hold_o,
  output logic       div_busy_o
);

  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  stage_t id_stage;

  logic div_hold;
  logic div_busy;
  logic load_use;
  logic branch_hazard;
  logic hazard_stall;

  div_stall_fsm #(
    .DIV_LATENCY(DIV_LATENCY)
  ) u_div_stall_fsm (
    .clk       (clk),
    .reset     (reset),
    .div_in_ex (ex_q.is_div),
    .ex_hold   (div_hold),
    .div_busy  (div_busy)
  );

  // x0 is never written, so drop reg_write before it can create a false hazard.
  always_comb begin
    id_stage           = STAGE_BUBBLE;
    id_stage.reg_write = reg_write_id_i && (rd_address_id_i != 5'd0);
    id_stage.rd        = rd_address_id_i;
    id_stage.is_load   = mem_to_reg_id_i;
    id_stage.is_div    = div_id_i;
  end

  always_comb begin
    load_use = ex_q.reg_write && ex_q.is_load &&
               src_match(ex_q.rd, rs1_address_id_i, rs2_address_id_i);

    // A branch compares in ID, so an ALU result still in EX or load data still
    // in MEM cannot be forwarded in time; everything else is forwarded.
    branch_hazard = branch_id_i &&
                    ((ex_q.reg_write &&
                      src_match(ex_q.rd, rs1_address_id_i, rs2_address_id_i)) ||
                     (mem_q.reg_write && mem_q.is_load &&
                      src_match(mem_q.rd, rs1_address_id_i, rs2_address_id_i)));

    hazard_stall = load_use || branch_hazard;
  end

  // Divide hold wins: EX keeps the divide and MEM takes bubbles. Otherwise a
  // hazard stall or a flush replaces the incoming ID instruction with a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
    end else begin
      wb_q <= mem_q;
      if (div_hold) begin
        mem_q <= STAGE_BUBBLE;
      end else begin
        mem_q <= ex_q;
        if (hazard_stall || flush_id_i) begin
          ex_q <= STAGE_BUBBLE;
        end else begin
          ex_q <= id_stage;
        end
      end
    end
  end

  // Combinational stall outputs are forced low while reset is applied so the
  // pipeline control reads idle even before the first edge.
  assign stall_o   = !reset && (div_hold || hazard_stall);
  assign ex_hold_o = !reset && div_hold;

  assign div_busy_o       = div_busy;
  assign reg_write_ex_o   = ex_q.reg_write;
  assign rd_address_ex_o  = ex_q.rd;
  assign reg_write_mem_o  = mem_q.reg_write;
  assign rd_address_mem_o = mem_q.rd;
  assign reg_write_wb_o   = wb_q.reg_write;
  assign rd_address_wb_o  = wb_q.rd;

  // Record fields that have no consumer past their stage.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{mem_q.is_div, wb_q.is_load, wb_q.is_div};

endmodule

// File: tb/tb_writeback_tracker.sv
// tb/tb_writeback_tracker.sv - directed self-checking bench for writeback_tracker

module tb_writeback_tracker;
  import writeback_tracker_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       reg_write_id_i;
  logic [4:0] rd_address_id_i;
  logic       mem_to_reg_id_i;
  logic       div_id_i;
  logic       branch_id_i;
  logic [4:0] rs1_address_id_i;
  logic [4:0] rs2_address_id_i;
  logic       flush_id_i;
  logic       reg_write_ex_o;
  logic [4:0] rd_address_ex_o;
  logic       reg_write_mem_o;
  logic [4:0] rd_address_mem_o;
  logic       reg_write_wb_o;
  logic [4:0] rd_address_wb_o;
  logic       stall_o;
  logic       ex_hold_o;
  logic       div_busy_o;

  int checks_total  = 0;
  int checks_passed = 0;
  int n_stall;

  writeback_tracker #(.DIV_LATENCY(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .reg_write_id_i   (reg_write_id_i),
    .rd_address_id_i  (rd_address_id_i),
    .mem_to_reg_id_i  (mem_to_reg_id_i),
    .div_id_i         (div_id_i),
    .branch_id_i      (branch_id_i),
    .rs1_address_id_i (rs1_address_id_i),
    .rs2_address_id_i (rs2_address_id_i),
    .flush_id_i       (flush_id_i),
    .reg_write_ex_o   (reg_write_ex_o),
    .rd_address_ex_o  (rd_address_ex_o),
    .reg_write_mem_o  (reg_write_mem_o),
    .rd_address_mem_o (rd_address_mem_o),
    .reg_write_wb_o   (reg_write_wb_o),
    .rd_address_wb_o  (rd_address_wb_o),
    .stall_o          (stall_o),
    .ex_hold_o        (ex_hold_o),
    .div_busy_o       (div_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic rw, input logic [4:0] rd, input logic ld, input logic dv,
                        input logic br, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic fl);
    reg_write_id_i   = rw;
    rd_address_id_i  = rd;
    mem_to_reg_id_i  = ld;
    div_id_i         = dv;
    branch_id_i      = br;
    rs1_address_id_i = rs1;
    rs2_address_id_i = rs2;
    flush_id_i       = fl;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    nop();
    step();
    step();
    check("rst_stall",   stall_o, 0);
    check("rst_ex_hold", ex_hold_o, 0);
    check("rst_busy",    div_busy_o, 0);
    check("rst_rw_ex",   reg_write_ex_o, 0);
    check("rst_rw_mem",  reg_write_mem_o, 0);
    check("rst_rw_wb",   reg_write_wb_o, 0);
    reset = 1'b0;

    // Load x5 then ADD x6,x5,x1: one stall, one EX bubble.
    set_id(1, 5, 1, 0, 0, 1, 0, 0);
    check("a_no_stall", stall_o, 0);
    step();
    set_id(1, 6, 0, 0, 0, 5, 1, 0);
    check("a_ex_load_rd", rd_address_ex_o, 5);
    check("a_ex_load_rw", reg_write_ex_o, 1);
    check("a_stall", stall_o, 1);
    step();
    check("a_ex_bubble", reg_write_ex_o, 0);
    check("a_mem_load_rw", reg_write_mem_o, 1);
    check("a_mem_load_rd", rd_address_mem_o, 5);
    check("a_unstall", stall_o, 0);
    step();
    nop();
    check("a_ex_add_rd", rd_address_ex_o, 6);
    check("a_wb_load_rd", rd_address_wb_o, 5);
    step();
    check("a_mem_add_rw", reg_write_mem_o, 1);
    check("a_mem_add_rd", rd_address_mem_o, 6);

    // Writes to x0 never show reg_write.
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    nop();
    check("b_ex_x0_rw", reg_write_ex_o, 0);
    step();
    check("b_mem_x0_rw", reg_write_mem_o, 0);
    step();
    check("b_wb_x0_rw", reg_write_wb_o, 0);

    // ADD x3 in EX, BEQ x3,x4 in ID: one stall.
    set_id(1, 3, 0, 0, 0, 1, 2, 0);
    step();
    set_id(0, 0, 0, 0, 1, 3, 4, 0);
    check("c1_stall", stall_o, 1);
    step();
    check("c1_stall_clear", stall_o, 0);
    check("c1_ex_bubble", reg_write_ex_o, 0);
    step();
    // Load x3 in EX, BEQ x3,x4 in ID: two stalls.
    set_id(1, 3, 1, 0, 0, 2, 0, 0);
    step();
    set_id(0, 0, 0, 0, 1, 3, 4, 0);
    check("c2_stall_ex", stall_o, 1);
    step();
    check("c2_stall_mem", stall_o, 1);
    step();
    check("c2_stall_clear", stall_o, 0);
    step();
    nop();

    // DIV x7 with latency 4.
    set_id(1, 7, 0, 1, 0, 1, 2, 0);
    step();
    nop();
    check("d_hold", ex_hold_o, 1);
    check("d_busy_idle", div_busy_o, 0);
    n_stall = 0;
    for (int i = 0; i < 20 && stall_o; i++) begin
      n_stall++;
      if (i > 0) check($sformatf("d_mem_bubble%0d", i), reg_write_mem_o, 0);
      step();
    end
    check("d_stall_cycles", n_stall, 4);
    check("d_ex_held_rd", rd_address_ex_o, 7);
    check("d_busy_last", div_busy_o, 1);
    check("d_hold_off", ex_hold_o, 0);
    step();
    check("d_mem_rw", reg_write_mem_o, 1);
    check("d_mem_rd", rd_address_mem_o, 7);
    check("d_busy_done", div_busy_o, 0);

    // Reset mid-divide at counter=2.
    set_id(1, 8, 0, 1, 0, 0, 0, 0);
    step();
    nop();
    step();
    step();
    check("e_busy_pre", div_busy_o, 1);
    reset = 1'b1;
    #1;
    check("e_rst_stall", stall_o, 0);
    check("e_rst_hold",  ex_hold_o, 0);
    check("e_rst_busy",  div_busy_o, 0);
    check("e_rst_rw_ex", reg_write_ex_o, 0);
    check("e_rst_rd_ex", rd_address_ex_o, 0);
    check("e_rst_rw_mem", reg_write_mem_o, 0);
    step();
    reset = 1'b0;
    step();
    check("e_no_stall", stall_o, 0);
    check("e_no_busy", div_busy_o, 0);
    step();
    check("e_no_stall2", stall_o, 0);

    // Flush with no stall bubbles EX; flush during a stall is ignored.
    set_id(1, 9, 0, 0, 0, 0, 0, 1);
    check("f_stall", stall_o, 0);
    step();
    check("f_flush_rw", reg_write_ex_o, 0);
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    step();
    set_id(1, 9, 0, 0, 0, 5, 0, 1);
    check("f_stall_on", stall_o, 1);
    step();
    check("f_ex_bubble", reg_write_ex_o, 0);
    check("f_stall_off", stall_o, 0);
    set_id(1, 9, 0, 0, 0, 5, 0, 0);
    step();
    check("f_ex_kept_rw", reg_write_ex_o, 1);
    check("f_ex_kept_rd", rd_address_ex_o, 9);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
